// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an iterative shift-add multiply.
// Latency: 1 cycle from accept to out_valid for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: the result is held in DONE until out_ready; a new op can be accepted on the consuming edge.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             ZF,
    output logic             CF,
    output logic             OF,
    output logic             NF,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int MSB   = WIDTH - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zf_q, zf_d, cf_q, cf_d, of_q, of_d, nf_q, nf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] alu_r;
    logic             alu_cf, alu_of;
    logic [WIDTH-1:0] mul_sum;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

    assign R  = r_q;
    assign ZF = zf_q;
    assign CF = cf_q;
    assign OF = of_q;
    assign NF = nf_q;

    // Single-cycle result and carry/overflow straight from the input operands
    always_comb begin
        add_w  = {1'b0, A} + {1'b0, B};
        sub_w  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_r  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (ALU_Sel)
            4'd0: alu_r = A & B;
            4'd1: alu_r = A | B;
            4'd2: begin
                alu_r  = add_w[MSB:0];
                alu_cf = add_w[WIDTH];
                alu_of = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
            end
            4'd3: begin
                // carry out of A + ~B + 1 is set when no borrow occurred
                alu_r  = sub_w[MSB:0];
                alu_cf = ~sub_w[WIDTH];
                alu_of = (A[MSB] == ~B[MSB]) && (sub_w[MSB] != A[MSB]);
            end
            4'd4: alu_r = {{(WIDTH-1){1'b0}}, (A < B)};
            4'd5: alu_r = ~(A | B);
            4'd7: alu_r = A << B[CNT_W-2:0];
            default: alu_r = '0;  // MUL is handled by the iterative path; 8..15 yield zero
        endcase
    end

    // Partial-product accumulate for the current multiplier bit
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    // Next-state: accept/consume handshake and multiply iteration
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        of_d     = of_q;
        nf_d     = nf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (ALU_Sel == 4'd6) begin
                        acc_d    = '0;
                        mcand_d  = A;
                        mplier_d = B;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        r_d     = alu_r;
                        zf_d    = (alu_r == '0);
                        cf_d    = alu_cf;
                        of_d    = alu_of;
                        nf_d    = alu_r[MSB];
                        state_d = ST_DONE;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // the last iteration writes the result directly, so out_valid
                // rises on the same edge the final partial product lands
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    r_d     = mul_sum;
                    zf_d    = (mul_sum == '0);
                    cf_d    = 1'b0;
                    of_d    = 1'b0;
                    nf_d    = mul_sum[MSB];
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            nf_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            nf_q     <= nf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: reset, single-cycle ops, multiply, backpressure, streaming, WIDTH=8.
// Results are compared against a plain-arithmetic reference model.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, R;
    logic [3:0]  ALU_Sel;
    logic        ZF, CF, OF, NF, busy;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, r8;
    logic [3:0]  sel8;
    logic        zf8, cf8, of8, nf8, busy8;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .ZF(ZF), .CF(CF), .OF(OF), .NF(NF), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .ALU_Sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .R(r8), .ZF(zf8), .CF(cf8), .OF(of8), .NF(nf8), .busy(busy8)
    );

    // Reference: computes the result from the arithmetic meaning of each opcode
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic cf, output logic of);
        logic [63:0] u;
        longint      s;
        r  = 32'h0;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                u  = {32'h0, a} + {32'h0, b};
                r  = u[31:0];
                cf = u[32];
                s  = longint'($signed(a)) + longint'($signed(b));
                of = (s != longint'($signed(r)));
            end
            4'd3: begin
                r  = a - b;
                cf = (a < b);
                s  = longint'($signed(a)) - longint'($signed(b));
                of = (s != longint'($signed(r)));
            end
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = ~(a | b);
            4'd6: begin
                u = {32'h0, a} * {32'h0, b};
                r = u[31:0];
            end
            4'd7: r = a << (b % 32);
            default: r = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one op from IDLE and wait (bounded) for out_valid; out_ready held low
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit hold_bad);
        @(negedge clk);
        in_valid = 1'b1; ALU_Sel = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        hold_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int stall);
        int lat; bit hold_bad;
        logic [31:0] er; logic ecf, eof, ezf, enf;
        ref_model(op, a, b, er, ecf, eof);
        ezf = (er == 32'h0);
        enf = er[31];
        do_op(op, a, b, lat, hold_bad);
        repeat (stall) @(posedge clk);
        #1;
        n_assert++;
        if (lat !== ((op == 4'd6) ? 33 : 1)) begin
            n_fail++; $display("FAIL %s latency op=%0d got=%0d want=%0d", name, op, lat, (op == 4'd6) ? 33 : 1);
        end
        n_assert++;
        if (hold_bad !== 1'b0) begin
            n_fail++; $display("FAIL %s busy/in_ready while computing op=%0d", name, op);
        end
        n_assert++;
        if (R !== er) begin
            n_fail++; $display("FAIL %s R op=%0d a=%h b=%h got=%h want=%h", name, op, a, b, R, er);
        end
        n_assert++;
        if ({ZF, CF, OF, NF} !== {ezf, ecf, eof, enf}) begin
            n_fail++; $display("FAIL %s flags(Z,C,O,N) op=%0d a=%h b=%h got=%b want=%b", name, op, a, b,
                               {ZF, CF, OF, NF}, {ezf, ecf, eof, enf});
        end
        consume();
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALU_Sel = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sel8 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if ({R, ZF, CF, OF, NF, out_valid, busy, in_ready} !== {32'h0, 6'b000000, 1'b1}) begin
            n_fail++; $display("FAIL reset_state R=%h flags=%b ov=%b busy=%b ir=%b", R, {ZF, CF, OF, NF}, out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // put a nonzero result in the registers so the mid-MUL reset is observable
        run_and_check("pre_reset_add", 4'd2, 32'd3, 32'd4, 0);
        @(negedge clk);
        in_valid = 1'b1; ALU_Sel = 4'd6; A = 32'd7; B = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({R, ZF, CF, OF, NF, out_valid, busy, in_ready} !== {32'h0, 6'b000000, 1'b1}) begin
            n_fail++; $display("FAIL reset_mid_mul R=%h flags=%b ov=%b busy=%b ir=%b", R, {ZF, CF, OF, NF}, out_valid, busy, in_ready);
        end
        #1 rst = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_assert++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard out_valid/busy rose after reset, got=1 want=0");
        end
    endtask

    task automatic test_arith();
        run_and_check("add_1_1",   4'd2, 32'd1, 32'd1, 0);
        run_and_check("sub_1_1",   4'd3, 32'd1, 32'd1, 0);
        run_and_check("sub_1_2",   4'd3, 32'd1, 32'd2, 0);
        run_and_check("add_ovf",   4'd2, 32'h7FFFFFFF, 32'd1, 0);
        run_and_check("add_carry", 4'd2, 32'hFFFFFFFF, 32'd1, 0);
        run_and_check("sub_ovf",   4'd3, 32'h80000000, 32'd1, 0);
    endtask

    task automatic test_mul();
        run_and_check("mul_12345", 4'd6, 32'h12345, 32'd100, 0);
        run_and_check("mul_ffff",  4'd6, 32'hFFFFFFFF, 32'd2, 0);
        run_and_check("mul_zero",  4'd6, 32'hDEADBEEF, 32'd0, 0);
        for (int i = 0; i < 4; i++) run_and_check("mul_rand", 4'd6, rand_operand(), rand_operand(), 0);
    endtask

    task automatic test_backpressure();
        int lat; bit hold_bad, bad;
        do_op(4'd4, 32'd2, 32'd1, lat, hold_bad);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (R !== 32'h0 || ZF !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        n_assert++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold R=%h ZF=%b ov=%b ir=%b want R=0 ZF=1 ov=1 ir=0", R, ZF, out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; ALU_Sel = 4'd1; A = 32'd1; B = 32'd2;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_assert++;
        if (out_valid !== 1'b1 || R !== 32'd3 || ZF !== 1'b0) begin
            n_fail++; $display("FAIL bp_back_to_back ov=%b R=%h ZF=%b want ov=1 R=3 ZF=0", out_valid, R, ZF);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  s_op [5];
        logic [31:0] s_a  [5];
        logic [31:0] s_b  [5];
        logic [3:0]  op;
        logic [31:0] a, b, er;
        logic        ecf, eof;
        s_op = '{4'd0, 4'd1, 4'd5, 4'd7, 4'd9};
        s_a  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h1234};
        s_b  = '{32'd1, 32'd0, 32'd0, 32'd31, 32'h5678};
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                op = s_op[i]; a = s_a[i]; b = s_b[i];
            end else begin
                do op = 4'($urandom_range(0, 15)); while (op == 4'd6);
                a = rand_operand(); b = rand_operand();
            end
            ref_model(op, a, b, er, ecf, eof);
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; ALU_Sel = op; A = a; B = b;
            @(posedge clk); #1;
            n_assert++;
            if (out_valid !== 1'b1 || R !== er || {ZF, CF, OF, NF} !== {er == 32'h0, ecf, eof, er[31]}) begin
                n_fail++; $display("FAIL stream[%0d] op=%0d ov=%b R=%h flags=%b want R=%h flags=%b", i, op, out_valid, R,
                                   {ZF, CF, OF, NF}, er, {er == 32'h0, ecf, eof, er[31]});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_assert++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain ov=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_and_check("random", 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), $urandom_range(0, 3));
    endtask

    task automatic test_width8();
        @(negedge clk);
        in_valid8 = 1'b1; sel8 = 4'd2; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        n_assert++;
        if (out_valid8 !== 1'b1 || r8 !== 8'h80 || {zf8, cf8, of8, nf8} !== 4'b0011) begin
            n_fail++; $display("FAIL w8_add_ovf ov=%b R=%h flags=%b want ov=1 R=80 flags=0011", out_valid8, r8, {zf8, cf8, of8, nf8});
        end
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk); #1;
        n_assert++;
        if (out_valid8 !== 1'b1 || r8 !== 8'h00 || {zf8, cf8, of8, nf8} !== 4'b1100) begin
            n_fail++; $display("FAIL w8_add_carry ov=%b R=%h flags=%b want ov=1 R=00 flags=1100", out_valid8, r8, {zf8, cf8, of8, nf8});
        end
        @(negedge clk);
        sel8 = 4'd7; a8 = 8'h01; b8 = 8'h07;
        @(posedge clk); #1;
        n_assert++;
        if (r8 !== 8'h80 || {zf8, cf8, of8, nf8} !== 4'b0001) begin
            n_fail++; $display("FAIL w8_sll R=%h flags=%b want R=80 flags=0001", r8, {zf8, cf8, of8, nf8});
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
